// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line levels and the TX scheduler state type.
// Imported by the frame shifter and the transmit scheduler.
package uart_pkg;

    localparam int FRAME_W   = 10;
    localparam int BIT_CNT_W = $clog2(FRAME_W);

    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } tx_state_t;

    typedef logic [FRAME_W-1:0] frame_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte request bus between the two producers and the TX scheduler.
// The producers drive valid/data (master); the scheduler answers with ready (slave).
interface uart_tx_sched_if;

    logic       Req0_valid;
    logic [7:0] Req0_data;
    logic       Req0_ready;
    logic       Req1_valid;
    logic [7:0] Req1_data;
    logic       Req1_ready;

    modport master (
        output Req0_valid, Req0_data, Req1_valid, Req1_data,
        input  Req0_ready, Req1_ready
    );

    modport slave (
        input  Req0_valid, Req0_data, Req1_valid, Req1_data,
        output Req0_ready, Req1_ready
    );

endinterface

// File: rtl/uart_frame_shifter.sv
// 10-bit parallel-load shifter; the MSB drives the line and vacated bits fill with the idle level.
// Load takes priority over shifting.
module uart_frame_shifter
    import uart_pkg::*;
(
    input  logic   Clk,
    input  logic   Reset,
    input  logic   Load,
    input  logic   Shift_en,
    input  frame_t Frame_in,
    output logic   Msb_out
);

    frame_t shift_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            shift_reg <= {FRAME_W{IDLE_LEVEL}};
        end else if (Load) begin
            shift_reg <= Frame_in;
        end else if (Shift_en) begin
            shift_reg <= {shift_reg[FRAME_W-2:0], IDLE_LEVEL};
        end
    end

    assign Msb_out = shift_reg[FRAME_W-1];

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler: accepts a byte from one of two requesters, frames it
// (start, 8 data LSB first, stop) and times each bit to CLKS_PER_BIT clocks on Serial_out.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic              Clk,
    input  logic              Reset,
    uart_tx_sched_if.slave    req,
    output logic              Serial_out,
    output logic              Busy,
    output logic              Grant_id
);

    localparam logic [CNT_W-1:0]     BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(FRAME_W - 1);

    tx_state_t            state_reg, state_next;
    logic [7:0]           data_reg, data_next;
    logic                 grant_reg, grant_next;
    logic                 rr_ptr_reg, rr_ptr_next;   // requester that wins the next tie
    logic [CNT_W-1:0]     baud_cnt_reg, baud_cnt_next;
    logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;

    logic [1:0] valid_vec;
    logic [7:0] data_arr [2];
    logic [1:0] ready_vec;
    logic       sel;
    logic       shift_load;
    logic       shift_en;
    logic       shift_msb;
    logic       baud_done;
    frame_t     frame_word;

    assign valid_vec   = {req.Req1_valid, req.Req0_valid};
    assign data_arr[0] = req.Req0_data;
    assign data_arr[1] = req.Req1_data;
    assign req.Req0_ready = ready_vec[0];
    assign req.Req1_ready = ready_vec[1];

    // Start bit goes out first, so data bit 0 sits just below it.
    assign frame_word[FRAME_W-1] = START_BIT;
    assign frame_word[0]         = STOP_BIT;
    for (genvar gi = 0; gi < 8; gi++) begin : g_frame
        assign frame_word[FRAME_W-2-gi] = data_reg[gi];
    end

    assign sel       = (valid_vec[0] && valid_vec[1]) ? rr_ptr_reg : valid_vec[1];
    assign baud_done = (baud_cnt_reg == BAUD_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= IDLE;
            data_reg     <= '0;
            grant_reg    <= 1'b0;
            rr_ptr_reg   <= 1'b0;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            data_reg     <= data_next;
            grant_reg    <= grant_next;
            rr_ptr_reg   <= rr_ptr_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        data_next     = data_reg;
        grant_next    = grant_reg;
        rr_ptr_next   = rr_ptr_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        ready_vec     = 2'b00;
        shift_load    = 1'b0;
        shift_en      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // Reset wins over a simultaneous request, so ready is withheld.
                if (!Reset && (valid_vec != 2'b00)) begin
                    ready_vec[sel] = 1'b1;
                    data_next      = data_arr[sel];
                    grant_next     = sel;
                    rr_ptr_next    = ~sel;
                    state_next     = LOAD;
                end
            end
            LOAD: begin
                shift_load    = 1'b1;
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
                state_next    = SEND;
            end
            SEND: begin
                if (baud_done) begin
                    shift_en      = 1'b1;
                    baud_cnt_next = '0;
                    bit_cnt_next  = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    uart_frame_shifter u_shifter (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (shift_load),
        .Shift_en (shift_en),
        .Frame_in (frame_word),
        .Msb_out  (shift_msb)
    );

    assign Serial_out = (state_reg == SEND) ? shift_msb : IDLE_LEVEL;
    assign Busy       = (state_reg != IDLE);
    assign Grant_id   = grant_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a cycle-timed reference model checks every cycle, plus a
// table of frames and directed sequences for reset, back-to-back and withdrawn requests.
module tb_uart_tx_sched;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 2 + 10 * CPB;

    logic clk = 1'b0;
    logic rst;
    logic ser, busy, gid;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    uart_tx_sched_if bus();

    uart_tx_sched #(.CLKS_PER_BIT(CPB), .CNT_W($clog2(CPB))) dut (
        .Clk        (clk),
        .Reset      (rst),
        .req        (bus),
        .Serial_out (ser),
        .Busy       (busy),
        .Grant_id   (gid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp_v);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s cyc=%0d got=timeout expected=event", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: frame timing derived from the handshake cycle by plain arithmetic.
    int         m_free_at = 0;
    int         m_t       = 0;
    logic [7:0] m_data    = 8'h00;
    logic       m_gid     = 1'b0;
    logic       m_tie     = 1'b0;
    logic       e_r0, e_r1, e_busy, e_ser, m_sel;
    int         m_k, m_b;

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    always @(negedge clk) begin
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (cyc >= m_free_at) begin
            e_busy = 1'b0;
            e_ser  = 1'b1;
        end else begin
            e_busy = 1'b1;
            m_k    = cyc - m_t;
            if (m_k < 2) e_ser = 1'b1;
            else begin
                m_b   = (m_k - 2) / CPB;
                e_ser = frame_bit(m_data, m_b);
            end
        end
        if (e_busy) check("model_gid", gid, m_gid);
        if (!rst && cyc >= m_free_at && (bus.Req0_valid || bus.Req1_valid)) begin
            m_sel = (bus.Req0_valid && bus.Req1_valid) ? m_tie : bus.Req1_valid;
            if (m_sel) e_r1 = 1'b1; else e_r0 = 1'b1;
            m_data    = m_sel ? bus.Req1_data : bus.Req0_data;
            m_gid     = m_sel;
            m_tie     = ~m_sel;
            m_t       = cyc;
            m_free_at = cyc + FRAME_CYC;
        end
        if (rst) begin
            m_free_at = cyc + 1;
            m_tie     = 1'b0;
        end
        check("model_ready0", bus.Req0_ready, e_r0);
        check("model_ready1", bus.Req1_ready, e_r1);
        check("model_busy", busy, e_busy);
        check("model_serial", ser, e_ser);
    end

    task automatic wait_hs(output int t, output logic which);
        t = -1;
        which = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.Req0_ready || bus.Req1_ready) begin
                t = cyc;
                which = bus.Req1_ready;
                return;
            end
            tick();
        end
        fail_now("handshake_wait");
    endtask

    task automatic wait_idle(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                t = cyc;
                return;
            end
            tick();
        end
        fail_now("idle_wait");
    endtask

    typedef struct {
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_gid;
        logic [9:0] exp_frame;   // bit 9 is transmitted first
    } vec_t;

    vec_t vecs [8];

    initial begin
        int         t, t2, tf, run, phase, nb;
        logic       which, done;
        logic [9:0] got;

        vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 10'b0101001011};
        vecs[1] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 10'b0010001001};
        vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 10'b0100010001};
        vecs[3] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 10'b0010001001};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h5A, 1'b1, 10'b0010110101};
        vecs[5] = '{1'b1, 1'b1, 8'h00, 8'hFF, 1'b0, 10'b0000000001};
        vecs[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 10'b0111111111};
        vecs[7] = '{1'b1, 1'b1, 8'h00, 8'hA5, 1'b1, 10'b0101001011};

        // Reset held with both requesters valid.
        rst = 1'b1;
        bus.Req0_valid = 1'b1; bus.Req0_data = 8'h11;
        bus.Req1_valid = 1'b1; bus.Req1_data = 8'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready0", bus.Req0_ready, 1'b0);
            check("rst_ready1", bus.Req1_ready, 1'b0);
            check("rst_serial", ser, 1'b1);
            check("rst_busy", busy, 1'b0);
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        check("first_ready0", bus.Req0_ready, 1'b1);
        check("first_ready1", bus.Req1_ready, 1'b0);
        t = cyc;
        tick();
        bus.Req0_valid = 1'b0; bus.Req1_valid = 1'b0;
        wait_idle(tf);
        check("first_len", tf - t, FRAME_CYC);

        // Table of frames.
        for (int v = 0; v < 8; v++) begin
            tick();
            bus.Req0_valid = vecs[v].v0; bus.Req0_data = vecs[v].d0;
            bus.Req1_valid = vecs[v].v1; bus.Req1_data = vecs[v].d1;
            wait_hs(t, which);
            if (t >= 0) begin
                check("tbl_grant", which, vecs[v].exp_gid);
                tick();
                bus.Req0_valid = 1'b0; bus.Req1_valid = 1'b0;
                repeat (1 + CPB / 2) tick();
                for (int b = 0; b < 10; b++) begin
                    @(negedge clk);
                    got[9-b] = ser;
                    check("tbl_gid", gid, vecs[v].exp_gid);
                    if (b < 9) repeat (CPB) tick();
                end
                check("tbl_frame", got, vecs[v].exp_frame);
                wait_idle(tf);
                check("tbl_busy_fall", tf - t, FRAME_CYC);
            end
        end

        // Back-to-back from Req0: 0x00 then 0xFF.
        tick();
        bus.Req0_valid = 1'b1; bus.Req0_data = 8'h00;
        wait_hs(t, which);
        tick();
        bus.Req0_data = 8'hFF;
        phase = 0; run = 0; t2 = -1; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.Req0_ready) t2 = cyc;
            case (phase)
                0: if (!ser) phase = 1;
                1: if (ser) begin phase = 2; run = 1; end
                default: if (ser) run++; else done = 1'b1;
            endcase
            tick();
            if (t2 >= 0) bus.Req0_valid = 1'b0;
        end
        check("b2b_done", done, 1'b1);
        check("b2b_gap", run, CPB + 2);
        check("b2b_hs_spacing", t2 - t, FRAME_CYC);
        wait_idle(tf);

        // Reset during data bit 3 of 0x5A.
        tick();
        bus.Req0_valid = 1'b1; bus.Req0_data = 8'h5A;
        wait_hs(t, which);
        tick();
        bus.Req0_valid = 1'b0;
        repeat (18) tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_serial", ser, 1'b1);
        check("midrst_busy", busy, 1'b0);
        nb = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            @(negedge clk);
            if (busy || ser !== 1'b1) nb++;
        end
        check("midrst_no_resend", nb, 0);
        tick();
        bus.Req1_valid = 1'b1; bus.Req1_data = 8'h33;
        wait_hs(t, which);
        check("midrst_req1_grant", which, 1'b1);
        tick();
        bus.Req1_valid = 1'b0;
        wait_idle(tf);
        check("midrst_req1_len", tf - t, FRAME_CYC);

        // Req1 valid pulsed while busy is never accepted.
        tick();
        bus.Req0_valid = 1'b1; bus.Req0_data = 8'h3C;
        wait_hs(t, which);
        tick();
        bus.Req0_valid = 1'b0;
        repeat (10) tick();
        bus.Req1_valid = 1'b1; bus.Req1_data = 8'h77;
        @(negedge clk);
        check("pulse_ready1", bus.Req1_ready, 1'b0);
        tick();
        bus.Req1_valid = 1'b0;
        wait_idle(tf);
        check("pulse_len", tf - t, FRAME_CYC);
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            if (busy) nb++;
        end
        check("pulse_no_frame", nb, 0);

        // Random traffic with occasional resets; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            tick();
            bus.Req0_valid = ($urandom_range(0, 3) == 0);
            bus.Req1_valid = ($urandom_range(0, 3) == 0);
            bus.Req0_data  = 8'($urandom);
            bus.Req1_data  = 8'($urandom);
            rst            = ($urandom_range(0, 399) == 0);
        end
        tick();
        rst = 1'b0;
        bus.Req0_valid = 1'b0; bus.Req1_valid = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side scheduler for the UART. It shares one serial transmit path between two byte requesters with round-robin arbitration, and wraps each byte into a 10-bit frame (start bit, 8 data bits LSB first, stop bit). It times every bit to CLKS_PER_BIT system clocks and drives the serial line. It sits between the byte producers (command/response logic) and the TX pin.

## Interface
Parameters:
- CLKS_PER_BIT, 434 — system clocks per serial bit (50 MHz / 115200); legal range ≥ 2.
- CNT_W, $clog2(CLKS_PER_BIT) — baud counter width.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  reset, synchronous, active-high.
- Req0_valid  input  1  requester 0 has a byte.
- Req0_data  input  8  requester 0 byte.
- Req0_ready  output  1  requester 0 byte accepted this cycle.
- Req1_valid  input  1  requester 1 has a byte.
- Req1_data  input  8  requester 1 byte.
- Req1_ready  output  1  requester 1 byte accepted this cycle.
- Serial_out  output  1  TX line; idles high.
- Busy  output  1  high whenever state ≠ IDLE.
- Grant_id  output  1  requester whose frame is in flight; valid while Busy.

## Operation
- States: IDLE, LOAD, SEND.
- IDLE:
  - If any ReqN_valid is high, select one requester. ReqN_ready is high combinationally for that requester only, in this cycle.
  - Transfer occurs on valid && ready. On transfer: latch the data, set Grant_id, go to LOAD.
  - Arbitration: round robin. If both requesters are valid, grant the one not served last. After reset, Req0 wins a tie.
- LOAD (1 cycle):
  - Load the frame shifter with {1'b0, d[0], d[1], …, d[7], 1'b1}, MSB transmitted first.
  - Clear the baud counter and the bit counter. Go to SEND.
- SEND:
  - Serial_out = shifter[9].
  - The baud counter runs 0..CLKS_PER_BIT-1.
  - At terminal count: shift left with 1 fill, increment the bit counter, reset the baud counter.
  - At terminal count with bit counter = 9: go to IDLE.
- Serial_out = 1 in IDLE and LOAD.
- ReqN_ready is never high outside IDLE. A requester may hold valid for the whole frame; only the IDLE cycle accepts it.
- Data on a non-granted requester is not sampled.

## Timing
- Reset values: state IDLE, Serial_out 1, Busy 0, Req0_ready/Req1_ready 0 unless in IDLE with valid, Grant_id 0, round-robin pointer → Req0, counters 0.
- Latency: handshake in cycle T → LOAD in T+1 → start bit on Serial_out from T+2.
- Each bit is exactly CLKS_PER_BIT cycles. A frame occupies cycles T+2 … T+1+10·CLKS_PER_BIT.
- Back-to-back: the earliest next handshake is the IDLE cycle immediately after the stop bit. The inter-frame gap is therefore stop bit + 2 cycles of high line (IDLE + LOAD).
- Reset mid-frame:
  - The frame is aborted; the next cycle is IDLE with Serial_out = 1.
  - The latched byte is discarded and the round-robin pointer returns to Req0.
  - Reset has priority over a simultaneous handshake: no transfer occurs.
- Valid dropped before handshake: no transfer, no state change.

## Structure
- Shared package uart_pkg:
  - FRAME_W = 10 and the state enumeration type.
  - IDLE_LEVEL = 1'b1, START_BIT = 1'b0, STOP_BIT = 1'b1.
- Sub-module uart_frame_shifter: 10-bit parallel-load, enable-gated left shifter with 1 fill.
  - Ports: Clk, Reset, Load, Shift_en, Frame_in[9:0], Msb_out.
  - The scheduler owns all counters, arbitration and the FSM.

## Test plan
- Reset defaults: hold Reset 3 cycles with both valids high → Serial_out=1, Busy=0, no ready during Reset; Req0 granted first after release.
- Single frame, CLKS_PER_BIT=4, Req0 sends 0xA5:
  - Serial_out from T+2 = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - Busy falls at T+42.
- Contention: both valid continuously, Req0=0x11, Req1=0x22 → grants alternate Req0, Req1, Req0; Grant_id matches each frame; ready is never high for both.
- Back-to-back from one requester (0x00 then 0xFF) → second start bit follows the first stop bit after exactly 2 extra high cycles; data bits 0×8 then 1×8.
- Reset mid-frame: assert Reset during data bit 3 of 0x5A → Serial_out=1 the next cycle, Busy=0, the byte is never resent; a subsequent Req1 request is served normally.
- Valid withdrawn: Req1_valid pulses for a cycle while Busy → no ready, no frame generated for it.
